// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Arbitrates stage stall requests, turns committed exceptions/ERET into a timed flush, and keeps statistics.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDOG_LIMIT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic        hang_o
);

  localparam logic [31:0]      ERET_CODE = 32'h0000000E;
  localparam int unsigned      HOLD_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned      WDOG_W    = $clog2(WDOG_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_LIMIT);

  typedef enum logic {
    ST_RUN,
    ST_FLUSH_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [31:0]         pc_q, pc_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [5:0]          stall_req_mask;
  logic [31:0]         redirect_pc;
  logic                exc_take;

  assign exc_take    = (state_q == ST_RUN) && (excepttype_i != 32'h0);
  assign redirect_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;

  // A stalled stage also freezes everything upstream of it, so each mask is a prefix of ones.
  always_comb begin
    // NOTE: every combinational output gets a default before the branches so no latch is inferred.
    stall_req_mask = 6'b000000;
    if (stallreq_mem)     stall_req_mask = 6'b011111;
    else if (stallreq_ex) stall_req_mask = 6'b001111;
    else if (stallreq_id) stall_req_mask = 6'b000111;
    else if (stallreq_if) stall_req_mask = 6'b000011;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_RUN;
      hold_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pc_d    = pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc_take && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH_HOLD;
          hold_d  = HOLD_INIT;
          pc_d    = redirect_pc;
        end
      end
      ST_FLUSH_HOLD: begin
        // Inputs seen here belong to squashed instructions and are ignored.
        if (hold_q <= HOLD_W'(1)) begin
          state_d = ST_RUN;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        hold_d  = '0;
      end
    endcase
  end

  // Output logic: zero-latency flush on exception, forced quiet during reset.
  always_comb begin
    stall_o  = 6'b000000;
    flush_o  = 1'b0;
    new_pc_o = 32'h0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (exc_take) begin
            flush_o  = 1'b1;
            new_pc_o = redirect_pc;
          end else begin
            stall_o  = stall_req_mask;
          end
        end
        ST_FLUSH_HOLD: begin
          flush_o  = 1'b1;
          new_pc_o = pc_q;
        end
        default: begin
          flush_o  = 1'b0;
        end
      endcase
    end
  end

  // Watchdog saturates at the limit so it never wraps back below it.
  always_comb begin
    if ((stall_o == 6'b000000) || flush_o) wdog_d = '0;
    else if (wdog_q == WDOG_MAX)            wdog_d = wdog_q;
    else                                    wdog_d = wdog_q + WDOG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= 32'h0;
      flush_cnt_o <= 32'h0;
      wdog_q      <= '0;
      hang_o      <= 1'b0;
    end else begin
      if (stall_o != 6'b000000) stall_cnt_o <= stall_cnt_o + 32'h1;
      if (exc_take)             flush_cnt_o <= flush_cnt_o + 32'h1;
      wdog_q <= wdog_d;
      if (wdog_d == WDOG_MAX)   hang_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: three pipeline_ctrl instances (flush length 1/3/4) share one directed stimulus
// and are compared every cycle against a behavioural model, plus hand-computed literal checks.
module tb_pipeline_ctrl;

  localparam int N = 3;
  localparam int FC[N] = '{1, 3, 4};
  localparam int WL[N] = '{8, 8, 1024};
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sr_if = 1'b0, sr_id = 1'b0, sr_ex = 1'b0, sr_mem = 1'b0;
  logic [31:0] exc = 32'h0, epc = 32'h0;

  logic [5:0]  stall[N];
  logic        flush[N];
  logic [31:0] npc[N];
  logic [31:0] scnt[N];
  logic [31:0] fcnt[N];
  logic        hang[N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .WDOG_LIMIT(8)) u0 (
    .clk(clk), .rst(rst), .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex),
    .stallreq_mem(sr_mem), .excepttype_i(exc), .cp0_epc_i(epc), .stall_o(stall[0]),
    .flush_o(flush[0]), .new_pc_o(npc[0]), .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0]),
    .hang_o(hang[0]));

  pipeline_ctrl #(.FLUSH_CYCLES(3), .WDOG_LIMIT(8)) u1 (
    .clk(clk), .rst(rst), .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex),
    .stallreq_mem(sr_mem), .excepttype_i(exc), .cp0_epc_i(epc), .stall_o(stall[1]),
    .flush_o(flush[1]), .new_pc_o(npc[1]), .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1]),
    .hang_o(hang[1]));

  pipeline_ctrl #(.FLUSH_CYCLES(4)) u2 (
    .clk(clk), .rst(rst), .stallreq_if(sr_if), .stallreq_id(sr_id), .stallreq_ex(sr_ex),
    .stallreq_mem(sr_mem), .excepttype_i(exc), .cp0_epc_i(epc), .stall_o(stall[2]),
    .flush_o(flush[2]), .new_pc_o(npc[2]), .stall_cnt_o(scnt[2]), .flush_cnt_o(fcnt[2]),
    .hang_o(hang[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: remaining flush cycles, latched redirect, counters, consecutive-stall run length.
  int          m_rem[N], n_rem[N];
  logic [31:0] m_pc[N], n_pc[N];
  logic [31:0] m_scnt[N], n_scnt[N];
  logic [31:0] m_fcnt[N], n_fcnt[N];
  int          m_wd[N], n_wd[N];
  bit          m_hang[N], n_hang[N];
  bit          model_valid = 1'b0;
  bit          n_from_rst = 1'b0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      bit          accept;
      e_stall = 6'b0;
      e_flush = 1'b0;
      e_pc    = 32'h0;
      accept  = 1'b0;
      if (!rst) begin
        if (m_rem[i] > 0) begin
          e_flush = 1'b1;
          e_pc    = m_pc[i];
        end else if (exc != 32'h0) begin
          accept  = 1'b1;
          e_flush = 1'b1;
          e_pc    = (exc == 32'hE) ? epc : VEC;
        end else if (sr_mem) e_stall = 6'b011111;
        else if (sr_ex)      e_stall = 6'b001111;
        else if (sr_id)      e_stall = 6'b000111;
        else if (sr_if)      e_stall = 6'b000011;
      end
      if (model_valid) begin
        check($sformatf("model u%0d stall_o", i),     32'(stall[i]), 32'(e_stall));
        check($sformatf("model u%0d flush_o", i),     32'(flush[i]), 32'(e_flush));
        check($sformatf("model u%0d new_pc_o", i),    npc[i],        e_pc);
        check($sformatf("model u%0d stall_cnt_o", i), scnt[i],       m_scnt[i]);
        check($sformatf("model u%0d flush_cnt_o", i), fcnt[i],       m_fcnt[i]);
        check($sformatf("model u%0d hang_o", i),      32'(hang[i]),  32'(m_hang[i]));
      end
      if (rst) begin
        n_rem[i] = 0; n_pc[i] = 32'h0; n_scnt[i] = 32'h0; n_fcnt[i] = 32'h0;
        n_wd[i] = 0;  n_hang[i] = 1'b0;
      end else begin
        n_scnt[i] = m_scnt[i] + ((e_stall != 6'b0) ? 32'h1 : 32'h0);
        n_fcnt[i] = m_fcnt[i] + (accept ? 32'h1 : 32'h0);
        n_rem[i]  = (m_rem[i] > 0) ? m_rem[i] - 1 : (accept ? FC[i] - 1 : 0);
        n_pc[i]   = accept ? e_pc : m_pc[i];
        n_wd[i]   = ((e_stall == 6'b0) || e_flush) ? 0 : m_wd[i] + 1;
        n_hang[i] = m_hang[i] || (n_wd[i] >= WL[i]);
      end
    end
    n_from_rst = rst;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      m_rem[i] = n_rem[i]; m_pc[i] = n_pc[i]; m_scnt[i] = n_scnt[i];
      m_fcnt[i] = n_fcnt[i]; m_wd[i] = n_wd[i]; m_hang[i] = n_hang[i];
    end
    if (n_from_rst) model_valid = 1'b1;
  end

  // Apply one cycle of inputs just after the edge, return at the following negedge.
  task automatic step(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                      input logic [31:0] e, input logic [31:0] p);
    @(posedge clk);
    #1;
    rst = r; sr_if = fi; sr_id = fd; sr_ex = fe; sr_mem = fm; exc = e; epc = p;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    idle();
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    idle();
    check("reset stall_o",     32'(stall[0]), 32'h0);
    check("reset flush_o",     32'(flush[0]), 32'h0);
    check("reset stall_cnt_o", scnt[0],       32'h0);
    check("reset flush_cnt_o", fcnt[0],       32'h0);
    check("reset hang_o",      32'(hang[0]),  32'h0);

    // Stall priority: ID+EX for three cycles
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0, 32'h0, 32'h0);
      check("prio id+ex stall_o", 32'(stall[0]), 32'h0F);
      check("prio id+ex flush_o", 32'(flush[0]), 32'h0);
    end
    idle();
    check("prio stall_cnt_o", scnt[0], 32'd3);
    step(0, 1, 0, 0, 1, 32'h0, 32'h0);
    check("prio mem+if stall_o", 32'(stall[0]), 32'h1F);
    step(0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("prio if stall_o", 32'(stall[0]), 32'h03);
    step(0, 1, 1, 0, 0, 32'h0, 32'h0);
    check("prio id+if stall_o", 32'(stall[0]), 32'h07);
    idle();
    check("prio stall_cnt_o after 6", scnt[0], 32'd6);

    // Exception beats a MEM stall
    do_reset();
    step(0, 0, 0, 0, 1, 32'h1, 32'h0);
    check("exc flush_o",  32'(flush[0]), 32'h1);
    check("exc stall_o",  32'(stall[0]), 32'h0);
    check("exc new_pc_o", npc[0],        32'hBFC00380);
    idle();
    check("exc flush_cnt_o", fcnt[0],       32'd1);
    check("exc flush drop",  32'(flush[0]), 32'h0);
    check("exc u1 hold pc",  npc[1],        32'hBFC00380);
    repeat (3) idle();

    // ERET redirects to EPC
    step(0, 0, 0, 0, 0, 32'hE, 32'h80001234);
    check("eret flush_o",  32'(flush[0]), 32'h1);
    check("eret new_pc_o", npc[0],        32'h80001234);
    idle();
    check("eret flush_cnt_o", fcnt[0], 32'd2);
    check("eret u2 hold pc",  npc[2],  32'h80001234);
    repeat (4) idle();

    // Three-cycle flush ignores stale exceptions and EPC changes
    do_reset();
    step(0, 0, 0, 0, 0, 32'h1, 32'h11111111);
    check("fc3 c1 flush_o", 32'(flush[1]), 32'h1);
    check("fc3 c1 new_pc",  npc[1],        32'hBFC00380);
    step(0, 0, 0, 0, 1, 32'h2, 32'h22222222);
    check("fc3 c2 flush_o", 32'(flush[1]), 32'h1);
    check("fc3 c2 new_pc",  npc[1],        32'hBFC00380);
    check("fc3 c2 stall_o", 32'(stall[1]), 32'h0);
    step(0, 0, 0, 0, 0, 32'hE, 32'h33333333);
    check("fc3 c3 flush_o", 32'(flush[1]), 32'h1);
    check("fc3 c3 new_pc",  npc[1],        32'hBFC00380);
    idle();
    check("fc3 c4 flush_o",     32'(flush[1]), 32'h0);
    check("fc3 c4 new_pc",      npc[1],        32'h0);
    check("fc3 flush_cnt_o",    fcnt[1],       32'd1);
    check("fc1 flush_cnt_o x3", fcnt[0],       32'd3);
    repeat (2) idle();

    // Watchdog trips on 8 consecutive stalled cycles
    do_reset();
    for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("wdog before 8th edge", 32'(hang[0]), 32'h0);
    idle();
    check("wdog hang_o set",     32'(hang[0]), 32'h1);
    check("wdog default limit",  32'(hang[2]), 32'h0);
    repeat (3) idle();
    check("wdog hang_o sticky",  32'(hang[0]), 32'h1);

    // 7 stalled + 1 idle, repeated, never trips
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 32'h0, 32'h0);
      idle();
    end
    check("wdog 7+1 hang_o",  32'(hang[0]), 32'h0);
    check("wdog 7+1 scnt",    scnt[0],      32'd21);

    // Reset in the second cycle of a four-cycle flush
    do_reset();
    step(0, 0, 0, 0, 0, 32'h1, 32'h0);
    check("rstflush c1 flush_o", 32'(flush[2]), 32'h1);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0);
    check("rstflush rst flush_o", 32'(flush[2]), 32'h0);
    check("rstflush rst new_pc",  npc[2],        32'h0);
    idle();
    check("rstflush after flush_o", 32'(flush[2]), 32'h0);
    check("rstflush after fcnt",    fcnt[2],       32'h0);
    check("rstflush after scnt",    scnt[2],       32'h0);
    step(0, 0, 0, 0, 0, 32'h1, 32'h0);
    check("rstflush re c1 flush_o", 32'(flush[2]), 32'h1);
    for (int k = 2; k <= 4; k++) begin
      step(0, 0, 0, (k == 3), 0, 32'h0, 32'h0);
      check($sformatf("rstflush re c%0d flush_o", k), 32'(flush[2]), 32'h1);
      check($sformatf("rstflush re c%0d new_pc", k),  npc[2],        32'hBFC00380);
      check($sformatf("rstflush re c%0d stall_o", k), 32'(stall[2]), 32'h0);
    end
    idle();
    check("rstflush re end flush_o", 32'(flush[2]), 32'h0);
    check("rstflush re fcnt",        fcnt[2],       32'd1);

    repeat (2) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
